bridge_dataslot_lookup: RTL and testbench
=========================================

Name: bridge_dataslot_lookup

Overview:
- Snoops host bridge writes into the dataslot table window and keeps a register shadow of all slot entries: a 16-bit id, a 32-bit size and a valid flag per slot.
- Serves core-side lookups: given a slot id, it returns whether the slot exists, its index and its size.
- Sits downstream of the dataslot table storage on the same bridge write stream. Its consumers are core loaders that need slot sizes without arbitrating for the bridge-side memory.

Parameters:
- BASE_ADDR, 32'hF800_2000, byte base of the dataslot window; low 8 bits are zero.
- NUM_SLOTS, 32, number of entries; each entry is 2 words (8 bytes), power of two, max 32.
- ID_WIDTH, 16, width of the slot id held in word0[ID_WIDTH-1:0].

Ports:
- clk  in  1  bridge clock; the whole block is on this one clock.
- reset  in  1  synchronous, active-high reset.
- bridge_addr  in  32  bridge byte address.
- bridge_wr  in  1  bridge write strobe, one cycle per word.
- bridge_wr_data  in  32  bridge write data (pocket::bridge_data_t).
- table_clear  in  1  one-cycle pulse that invalidates all entries.
- req_valid  in  1  lookup request.
- req_ready  out  1  block can accept a request.
- req_id  in  ID_WIDTH  slot id to find.
- resp_valid  out  1  lookup result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_found  out  1  a matching valid entry exists.
- resp_index  out  5  index of the matching entry; 0 if not found.
- resp_size  out  32  size word of the matching entry; 0 if not found.

Behaviour:
- Reset: all valid flags=0, ids=0, sizes=0, FSM=IDLE. Outputs: req_ready=1, resp_valid=0, resp_found=0, resp_index=0, resp_size=0.
- Snoop hit: bridge_wr && bridge_addr[31:8]==BASE_ADDR[31:8] && bridge_addr[7:3]<NUM_SLOTS.
  - Index = addr[7:3]; word select = addr[2]; addr[1:0] ignored.
  - Word0 write: id <= wr_data[ID_WIDTH-1:0]; valid <= 1.
  - Word1 write: size <= wr_data. Valid is unchanged, so a size written before its id stays invisible.
  - Writes outside the window, or to indices >= NUM_SLOTS, are ignored.
- Update timing: a snooped write is visible to comparisons from the next cycle on.
- table_clear: all valid flags <= 0 next cycle; ids and sizes are retained.
  - If table_clear and a word0 snoop hit occur in the same cycle, clear wins for every entry except the written one, which ends valid.
- FSM states IDLE, SCAN, RESP.
  - IDLE: req_ready=1. On req_valid, latch req_id, idx<=0, go SCAN.
  - SCAN: req_ready=0. Each cycle compare entry idx (valid && id==latched id).
    - Match: latch found=1, index=idx, size=size[idx]; go RESP.
    - No match and idx==NUM_SLOTS-1: latch found=0, index=0, size=0; go RESP.
    - Otherwise idx<=idx+1.
  - RESP: resp_valid=1 and the result is held stable until resp_ready. On resp_valid && resp_ready go IDLE. No back-to-back accept in that cycle; req_ready rises the following cycle.
- Latency: request accepted at edge E. A match at entry k gives resp_valid high after edge E+k+1. A miss gives resp_valid after edge E+NUM_SLOTS.
- Lowest matching index wins on duplicate ids.
- Snoop writes and table_clear during SCAN are honoured. The comparison at a given idx uses the register contents of that cycle.
- resp_* outputs are registers. They hold their last value in IDLE, but resp_valid=0 there.
- Reset mid-scan or mid-RESP: return to IDLE and drop the result; no response is produced.

Decomposition:
- pocket package gains:
  - dataslot_entry_t struct {valid, id[15:0], size[31:0]}.
  - DATASLOT_BASE constant.
  - DATASLOT_NUM constant.
- Natural sub-module: bridge_dataslot_shadow. It holds the snoop decode and the entry register array, with a combinational read port by index. The FSM stays in the top module.

Test Plan:
- Write word0=0x0000_0003 and word1=0x0001_0000 to BASE+0x10 (entry 2); request id 3 -> resp_valid 3 cycles after accept, found=1, index=2, size=0x10000.
- Empty table after reset, request id 7 -> resp after 32 cycles, found=0, index=0, size=0.
- Id 5 written into entries 4 and 9 -> found=1, index=4; clear entry 4's id to 6, request 5 again -> index=9.
- Entry 1 populated with id 8, table_clear pulse, request id 8 -> found=0; rewrite word0 id 8 -> found=1 and size equals the size written before the clear.
- Hold resp_ready=0 for 10 cycles -> resp_valid and the result stay stable and req_ready=0; then resp_ready=1 -> IDLE, with req_ready=1 one cycle later.
- Word0 write of id 2 to entry 20 while a lookup for id 2 is scanning at idx 10 -> found=1, index=20. Separately, assert reset mid-scan -> no resp_valid, and req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/bridge_dataslot_lookup_pkg.sv
// Shared types and constants for the dataslot shadow and lookup block.
package bridge_dataslot_lookup_pkg;

    typedef logic [31:0] bridge_data_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] id;
        logic [31:0] size;
    } dataslot_entry_t;

    localparam logic [31:0] DATASLOT_BASE = 32'hF800_2000;
    localparam int          DATASLOT_NUM  = 32;

endpackage

// File: rtl/bridge_dataslot_shadow.sv
// Snoops bridge writes into the dataslot window and keeps a register copy
// of every entry, with a combinational read port by index.
module bridge_dataslot_shadow
    import bridge_dataslot_lookup_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DATASLOT_BASE,
    parameter int          NUM_SLOTS = DATASLOT_NUM,
    parameter int          ID_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         bridge_addr,
    input  logic                bridge_wr,
    input  bridge_data_t        bridge_wr_data,
    input  logic                table_clear,
    input  logic [4:0]          rd_index,
    output logic                rd_valid,
    output logic [ID_WIDTH-1:0] rd_id,
    output logic [31:0]         rd_size
);

    logic [NUM_SLOTS-1:0] valid_q;
    logic [ID_WIDTH-1:0]  id_q   [NUM_SLOTS];
    logic [31:0]          size_q [NUM_SLOTS];

    logic       hit;
    logic [4:0] wr_index;
    logic       wr_word1;
    wire        unused_addr = &{1'b0, bridge_addr[1:0]};

    assign wr_index = bridge_addr[7:3];
    assign wr_word1 = bridge_addr[2];
    assign hit      = bridge_wr
                   && (bridge_addr[31:8] == BASE_ADDR[31:8])
                   && (32'(wr_index) < NUM_SLOTS);

    // The written entry ends valid even when a clear lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                id_q[i]   <= '0;
                size_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (hit && !wr_word1 && wr_index == 5'(i)) begin
                    valid_q[i] <= 1'b1;
                    id_q[i]    <= bridge_wr_data[ID_WIDTH-1:0];
                end else if (table_clear) begin
                    valid_q[i] <= 1'b0;
                end
                if (hit && wr_word1 && wr_index == 5'(i)) begin
                    size_q[i] <= bridge_wr_data;
                end
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_id    = id_q[rd_index];
    assign rd_size  = size_q[rd_index];

endmodule

// File: rtl/bridge_dataslot_lookup.sv
// Core-side slot lookup: sequential scan of the shadowed dataslot table,
// one entry per cycle, lowest matching index wins.
module bridge_dataslot_lookup
    import bridge_dataslot_lookup_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DATASLOT_BASE,
    parameter int          NUM_SLOTS = DATASLOT_NUM,
    parameter int          ID_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         bridge_addr,
    input  logic                bridge_wr,
    input  bridge_data_t        bridge_wr_data,
    input  logic                table_clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_WIDTH-1:0] req_id,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_found,
    output logic [4:0]          resp_index,
    output logic [31:0]         resp_size
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [4:0]          scan_idx;
    logic [ID_WIDTH-1:0] id_q;
    logic                rd_valid;
    logic [ID_WIDTH-1:0] rd_id;
    logic [31:0]         rd_size;
    logic                match;
    logic                last;

    bridge_dataslot_shadow #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_SLOTS (NUM_SLOTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_shadow (
        .clk            (clk),
        .reset          (reset),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .table_clear    (table_clear),
        .rd_index       (scan_idx),
        .rd_valid       (rd_valid),
        .rd_id          (rd_id),
        .rd_size        (rd_size)
    );

    assign match = rd_valid && (rd_id == id_q);
    assign last  = (scan_idx == 5'(NUM_SLOTS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = SCAN;
            end
            SCAN: begin
                if (match || last) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers hold their value outside of SCAN.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx   <= '0;
            id_q       <= '0;
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_size  <= '0;
        end else if (state_q == IDLE && req_valid) begin
            id_q     <= req_id;
            scan_idx <= '0;
        end else if (state_q == SCAN) begin
            if (match) begin
                resp_found <= 1'b1;
                resp_index <= scan_idx;
                resp_size  <= rd_size;
            end else if (last) begin
                resp_found <= 1'b0;
                resp_index <= '0;
                resp_size  <= '0;
            end else begin
                scan_idx <= scan_idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_bridge_dataslot_lookup.sv
// Directed bench for bridge_dataslot_lookup: table-driven lookups plus
// hand-written sequences for clear, backpressure, mid-scan writes and reset.
module tb_bridge_dataslot_lookup;

    localparam logic [31:0] BASE = 32'hF800_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        table_clear;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_id;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_found;
    logic [4:0]  resp_index;
    logic [31:0] resp_size;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bridge_dataslot_lookup dut (
        .clk            (clk),
        .reset          (reset),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .table_clear    (table_clear),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_id         (req_id),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_found     (resp_found),
        .resp_index     (resp_index),
        .resp_size      (resp_size)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] id;
        int          lat;
        logic        found;
        logic [4:0]  idx;
        logic [31:0] size;
    } vec_t;

    wr_t  wrs  [8];
    vec_t vecs [4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bwrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bridge_addr    = a;
        bridge_wr_data = d;
        bridge_wr      = 1'b1;
        @(posedge clk);
        #1 bridge_wr = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [15:0] id,
                          input int lat, input logic f,
                          input logic [4:0] ix, input logic [31:0] sz,
                          input int inj_n, input logic [31:0] inj_a,
                          input logic [31:0] inj_d);
        int n;
        @(negedge clk);
        chk({nm, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_id    = id;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!resp_valid && n < 64) begin
            if (n == inj_n) begin
                bridge_addr    = inj_a;
                bridge_wr_data = inj_d;
                bridge_wr      = 1'b1;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            bridge_wr = 1'b0;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " found"}, 64'(resp_found), 64'(f));
        chk({nm, " index"}, 64'(resp_index), 64'(ix));
        chk({nm, " size"}, 64'(resp_size), 64'(sz));
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({nm, " resp_drop"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int   n;
        logic seen;

        wrs[0] = '{BASE + 32'h10, 32'h0000_0003};
        wrs[1] = '{BASE + 32'h14, 32'h0001_0000};
        wrs[2] = '{32'hF800_1F10, 32'h0000_0055};
        wrs[3] = '{32'hF800_2100, 32'h0000_0003};
        wrs[4] = '{BASE + 32'h20, 32'h0000_0005};
        wrs[5] = '{BASE + 32'h24, 32'h0000_0444};
        wrs[6] = '{BASE + 32'h48, 32'h0000_0005};
        wrs[7] = '{BASE + 32'h4C, 32'h0000_0999};

        vecs[0] = '{"id3_e2",   16'h0003, 3,  1'b1, 5'd2,  32'h0001_0000};
        vecs[1] = '{"id5_dup",  16'h0005, 5,  1'b1, 5'd4,  32'h0000_0444};
        vecs[2] = '{"id0_miss", 16'h0000, 32, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{"id11_e12", 16'h0011, 13, 1'b1, 5'd12, 32'h0000_CAFE};

        reset          = 1'b1;
        bridge_addr    = '0;
        bridge_wr      = 1'b0;
        bridge_wr_data = '0;
        table_clear    = 1'b0;
        req_valid      = 1'b0;
        req_id         = '0;
        resp_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset outputs",
            {25'd0, req_ready, resp_valid, resp_found, resp_index, resp_size},
            {25'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0});

        lookup("empty_id7", 16'h0007, 32, 1'b0, 5'd0, 32'd0, -1, 0, 0);

        foreach (wrs[i]) bwrite(wrs[i].addr, wrs[i].data);
        bwrite(BASE + 32'h3C, 32'h0000_1234);
        bwrite(BASE + 32'h63, 32'h000A_0011);
        bwrite(BASE + 32'h67, 32'h0000_CAFE);

        foreach (vecs[i])
            lookup(vecs[i].name, vecs[i].id, vecs[i].lat, vecs[i].found,
                   vecs[i].idx, vecs[i].size, -1, 0, 0);

        bwrite(BASE + 32'h20, 32'h0000_0006);
        lookup("id5_after", 16'h0005, 10, 1'b1, 5'd9, 32'h999, -1, 0, 0);

        bwrite(BASE + 32'h08, 32'h0000_0008);
        bwrite(BASE + 32'h0C, 32'h0000_0088);
        lookup("id8_pre", 16'h0008, 2, 1'b1, 5'd1, 32'h88, -1, 0, 0);
        @(negedge clk);
        table_clear = 1'b1;
        @(posedge clk);
        #1 table_clear = 1'b0;
        lookup("id8_clr", 16'h0008, 32, 1'b0, 5'd0, 32'd0, -1, 0, 0);
        lookup("id3_clr", 16'h0003, 32, 1'b0, 5'd0, 32'd0, -1, 0, 0);
        bwrite(BASE + 32'h08, 32'h0000_0008);
        lookup("id8_rewr", 16'h0008, 2, 1'b1, 5'd1, 32'h88, -1, 0, 0);

        @(negedge clk);
        table_clear    = 1'b1;
        bridge_addr    = BASE + 32'h10;
        bridge_wr_data = 32'h0000_0003;
        bridge_wr      = 1'b1;
        @(posedge clk);
        #1 table_clear = 1'b0;
        bridge_wr = 1'b0;
        lookup("clrwr_id8", 16'h0008, 32, 1'b0, 5'd0, 32'd0, -1, 0, 0);
        lookup("clrwr_id3", 16'h0003, 3, 1'b1, 5'd2, 32'h1_0000, -1, 0, 0);

        @(negedge clk);
        req_valid = 1'b1;
        req_id    = 16'h0003;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold stable",
                {25'd0, resp_valid, req_ready, resp_found, resp_index,
                 resp_size},
                {25'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0001_0000});
        end
        resp_ready = 1'b1;
        chk("hold accept req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("hold release",
            {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});

        lookup("midscan_id2", 16'h0002, 21, 1'b1, 5'd20, 32'd0,
               10, BASE + 32'hA0, 32'h0000_0002);

        @(negedge clk);
        req_valid = 1'b1;
        req_id    = 16'h0099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid ready",
            {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("rst_mid no resp", 64'(seen), 64'd0);
        lookup("rst_empty_id3", 16'h0003, 32, 1'b0, 5'd0, 32'd0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
